ysyx_24120013_idu: RTL
======================

# ysyx_24120013_idu

Instruction decode stage, directly upstream of the execute stage. It accepts fetched instruction words from the fetch stage over a valid/ready handshake and decodes them into immediate, register-index, destination and command fields. It registers the result and presents it to the execute stage over a second valid/ready handshake, with a one-entry skid buffer so that `in_ready` never depends combinationally on `out_ready`. It also detects `ebreak` and illegal encodings, and holds a sticky halt plus a retired-decode counter for simulation control.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of the PC.
- `DATA_WIDTH`, 32: width of the instruction word and counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous reset, active-low.
- `in_valid`, input, 1: fetch stage offers an instruction.
- `in_ready`, output, 1: decode can accept this cycle.
- `in_inst`, input, DATA_WIDTH: instruction word.
- `in_pc`, input, ADDR_WIDTH: PC of the instruction.
- `out_valid`, output, 1: decoded word valid.
- `out_ready`, input, 1: execute stage accepts.
- `out_pc`, output, ADDR_WIDTH: PC carried through.
- `out_imm`, output, 20: sign-extended I-type immediate.
- `out_src1`, output, 5: rs1 = inst[19:15].
- `out_src2`, output, 5: rs2 = inst[24:20].
- `out_des`, output, 5: rd = inst[11:7].
- `out_command`, output, 2: 01 addi, 10 ebreak, 00 illegal/none.
- `out_illegal`, output, 1: decoded word is an unsupported encoding.
- `halt`, output, 1: sticky; an ebreak or illegal instruction was accepted.
- `inst_cnt`, output, DATA_WIDTH: count of accepted instructions.

## Operation
- Accept: `in_fire = in_valid & in_ready`. Output handshake: `out_fire = out_valid & out_ready`.
- `in_ready = ~skid_valid & (state == RUN)`. This signal is registered state only and has no path from `out_ready`.
- Decode is combinational on `in_inst`:
  - addi: opcode 0010011 and funct3 000. command = 01; imm = {{8{inst[31]}}, inst[31:20]}.
  - ebreak: inst == 0x00100073 exactly. command = 10; imm = 0.
  - Anything else: command = 00, illegal = 1, imm = 0.
  - src1, src2, des, pc: always taken from the raw fields regardless of command.
- Buffering (output register OR, skid register SK):
  - If OR is empty or `out_fire`, OR loads SK when SK is valid, otherwise OR loads the decoded input when `in_fire`, otherwise OR goes empty.
  - If SK loaded OR and `in_fire` in the same cycle, the new word goes into SK.
  - If OR is held (valid and not `out_fire`) and `in_fire`, the decoded word goes into SK.
  - SK empties whenever it moves into OR.
  - Program order is always preserved.
- State machine:
  - RUN → HALT on an `in_fire` whose command is 10 or whose illegal flag is 1.
  - HALT is absorbing until reset. In HALT, `in_ready` = 0 and `in_valid` is ignored.
  - Words already in OR/SK, including the halting instruction itself, still drain to the execute stage normally.
- `halt` = (state == HALT).
- `inst_cnt` increments by 1 on every `in_fire` and wraps modulo 2^DATA_WIDTH. The halting instruction is counted.

## Timing
- Reset (asynchronous, `rst` low) forces:
  - `out_valid` = 0 and SK empty.
  - `out_pc`, `out_imm`, `out_src1`, `out_src2`, `out_des`, `out_command`, `out_illegal` = 0.
  - `halt` = 0, `inst_cnt` = 0, state = RUN.
  - `in_ready` = 1 as long as reset is held and after release.
- Outputs go to reset values immediately on `rst` assertion, independent of `clk`.
- Latency: the word accepted at edge N appears on `out_*` with `out_valid` = 1 after edge N when OR was free.
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- Backpressure:
  - With `out_ready` held at 0, exactly two words are accepted (OR + SK).
  - `in_ready` drops after the edge that fills SK.
  - `in_ready` rises the cycle after SK drains.
- `out_*` fields are stable while `out_valid` = 1 and `out_ready` = 0.
- `halt` rises in the cycle after the edge that accepted the ebreak or illegal word. `in_ready` falls at that same edge.
- Simultaneous in_fire and out_fire with SK empty: OR is replaced by the new word, with no bubble.

## Test plan
- Basic addi: feed 0x00500093 at pc 0x80000000 with `out_ready` = 1. Next cycle, `out_valid` = 1, imm = 0x00005, src1 = 0, des = 1, command = 01, illegal = 0. `inst_cnt` = 1.
- Negative immediate: 0xFFF08113 gives imm = 0xFFFFF, src1 = 1, des = 2, command = 01.
- Backpressure: hold `out_ready` = 0 and offer words A, B, C back-to-back.
  - A and B are accepted; `in_ready` = 0 with C still pending.
  - After raising `out_ready`: A, then B, then C are delivered on consecutive cycles with no duplicates or drops.
- Ebreak: stream addi, 0x00100073, addi.
  - The ebreak word is delivered with command = 10.
  - `halt` = 1 the cycle after its acceptance.
  - The third word is never accepted; `inst_cnt` = 2.
- Illegal: 0x00000000 gives command = 00, `out_illegal` = 1, `halt` = 1, `in_ready` = 0.
- Reset mid-operation: with OR and SK full, pull `rst` low between clock edges.
  - `out_valid` = 0 and `inst_cnt` = 0 immediately.
  - After release: `in_ready` = 1, `halt` = 0, and the next accepted word appears with 1-cycle latency.

Source files
------------

// File: rtl/ysyx_24120013_idu.sv
// ysyx_24120013_idu -- instruction decode stage.
//
// Takes fetched instruction words over a valid/ready handshake and decodes
// addi / ebreak. Anything else is flagged illegal. The decoded word is
// registered and offered to the execute stage over a second valid/ready
// handshake. A one-entry skid buffer keeps in_ready free of any combinational
// path from out_ready. A sticky halt is raised once an ebreak or illegal word
// has been accepted, and a retired-decode counter is kept for simulation
// control.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   in_valid / in_ready / in_inst / in_pc   : fetch-side handshake
//   out_valid / out_ready                   : execute-side handshake
//   out_pc, out_imm (20b sign-extended I-imm), out_src1, out_src2, out_des,
//   out_command (01 addi, 10 ebreak, 00 none), out_illegal
//   halt     : sticky, set after an ebreak/illegal word is accepted
//   inst_cnt : number of accepted instructions (wraps)
module ysyx_24120013_idu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [19:0]           out_imm,
  output logic [4:0]            out_src1,
  output logic [4:0]            out_src2,
  output logic [4:0]            out_des,
  output logic [1:0]            out_command,
  output logic                  out_illegal,
  output logic                  halt,
  output logic [DATA_WIDTH-1:0] inst_cnt
);

  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_ADDI   = 2'b01;
  localparam logic [1:0] CMD_EBREAK = 2'b10;
  localparam logic [DATA_WIDTH-1:0] EBREAK_INST = DATA_WIDTH'(32'h0010_0073);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [19:0]           imm;
    logic [4:0]            src1;
    logic [4:0]            src2;
    logic [4:0]            des;
    logic [1:0]            command;
    logic                  illegal;
  } word_t;

  state_t                state_reg, state_next;
  word_t                 dec_word;
  word_t                 or_word_reg, sk_word_reg;
  logic                  or_valid_reg, sk_valid_reg;
  logic [DATA_WIDTH-1:0] cnt_reg;
  logic                  in_fire, out_fire, stops;

  // in_ready is a function of registered state only.
  assign in_ready = ~sk_valid_reg & (state_reg == RUN);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = or_valid_reg & out_ready;

  // Combinational decode of the incoming word.
  always_comb begin
    dec_word      = '0;
    dec_word.pc   = in_pc;
    dec_word.src1 = in_inst[19:15];
    dec_word.src2 = in_inst[24:20];
    dec_word.des  = in_inst[11:7];
    if (in_inst[6:0] == 7'b0010011 && in_inst[14:12] == 3'b000) begin
      dec_word.command = CMD_ADDI;
      dec_word.imm     = {{8{in_inst[31]}}, in_inst[31:20]};
    end else if (in_inst == EBREAK_INST) begin
      dec_word.command = CMD_EBREAK;
    end else begin
      dec_word.command = CMD_NONE;
      dec_word.illegal = 1'b1;
    end
  end

  assign stops = (dec_word.command == CMD_EBREAK) | dec_word.illegal;

  // Halt FSM: RUN drops to HALT on accepting a stopping word; HALT absorbs.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (in_fire && stops) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (in_fire) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Output register plus skid register. The skid entry is always older than
  // any new input, so it takes priority whenever the output register frees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      or_valid_reg <= 1'b0;
      or_word_reg  <= '0;
      sk_valid_reg <= 1'b0;
      sk_word_reg  <= '0;
    end else if (!or_valid_reg || out_fire) begin
      if (sk_valid_reg) begin
        or_valid_reg <= 1'b1;
        or_word_reg  <= sk_word_reg;
        // Cannot coincide with in_fire today (in_ready needs an empty skid),
        // but keep the ordering correct if that ever changes.
        sk_valid_reg <= in_fire;
        if (in_fire) sk_word_reg <= dec_word;
      end else if (in_fire) begin
        or_valid_reg <= 1'b1;
        or_word_reg  <= dec_word;
      end else begin
        or_valid_reg <= 1'b0;
      end
    end else if (in_fire) begin
      sk_valid_reg <= 1'b1;
      sk_word_reg  <= dec_word;
    end
  end

  assign out_valid   = or_valid_reg;
  assign out_pc      = or_word_reg.pc;
  assign out_imm     = or_word_reg.imm;
  assign out_src1    = or_word_reg.src1;
  assign out_src2    = or_word_reg.src2;
  assign out_des     = or_word_reg.des;
  assign out_command = or_word_reg.command;
  assign out_illegal = or_word_reg.illegal;
  assign halt        = (state_reg == HALT);
  assign inst_cnt    = cnt_reg;

endmodule
